pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register for the MIPS pipeline, carrying an instruction word and its PC between stages. It replaces plain always-load stage registers with a valid/ready handshake backed by a 2-entry skid buffer. The buffer gives full throughput under back-pressure and supports synchronous flush for branch/jump squash. It is instantiated between IF/ID, and reusable for ID/EX, EX/MEM and MEM/WB, with a widened payload.

Parameters:
INSTR_W, 32, width of instruction/payload field
PC_W, 32, width of PC field
NOP_INSTR, 32'h0000_0000, instruction value loaded on reset and flush (sll $0,$0,0)
CNT_W, 16, width of statistics counters (used only with PIPE_STAGE_STATS_EN)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
flush_i  input  1  synchronous squash of all held entries
in_valid  input  1  upstream beat valid
in_ready  output  1  stage can accept a beat
in_instr  input  INSTR_W  upstream instruction
in_pc  input  PC_W  upstream PC
out_valid  output  1  downstream beat valid
out_ready  input  1  downstream accepts beat
out_instr  output  INSTR_W  instruction to next stage
out_pc  output  PC_W  PC to next stage

Behaviour:
- reset/clk: reset is asynchronous, active-low; clock is clk.
- Handshake terms:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- Storage: main register (drives outputs) plus skid register.
- State: EMPTY, FULL (main only), SKID (main + skid).
- Reset (reset==0):
  - state=EMPTY, out_valid=0, in_ready=0
  - main/skid instr=NOP_INSTR, pc=0
- After reset release: in_ready=1 in the first cycle.
- Derived outputs:
  - out_valid = (state!=EMPTY)
  - in_ready = (state!=SKID) & reset deasserted
  - Both are decoded from the state register only; no combinational path from out_ready or in_valid.
- Transitions (no flush):
  - EMPTY: push -> FULL, main<=in.
  - FULL: push&pop -> FULL, main<=in. push only -> SKID, skid<=in. pop only -> EMPTY, main retains last value. Neither -> hold.
  - SKID: push is impossible. pop -> FULL, main<=skid. No pop -> hold.
- Latency: a beat pushed in cycle N is visible on out_* with out_valid=1 in cycle N+1.
- Throughput: 1 beat/cycle sustained while out_ready=1.
- Ordering: strict FIFO. The skid entry never overtakes main.
- Stability: while out_valid=1 and out_ready=0, out_instr/out_pc are held constant.
- Flush (flush_i=1 at a clock edge):
  - Next state=EMPTY; main and skid load NOP_INSTR/pc=0.
  - Flush has priority: a simultaneous push is discarded.
  - A simultaneous pop still completes downstream in that cycle.
- Flush vs SKID: flush while in SKID drops both entries. in_ready returns to 1 the next cycle.
- Mid-operation reset: asynchronous, same values as the reset row above; in-flight beats are lost.
- in_valid may drop without a transfer (no upstream stickiness is required). out_valid, once asserted, stays asserted until pop or flush.

Optional Feature:
Macro PIPE_STAGE_STATS_EN.
- Defined — adds two outputs:
  - stall_cnt[CNT_W]: increments each cycle with out_valid=1 & out_ready=0.
  - flush_drop_cnt[CNT_W]: adds the number of valid entries discarded by a flush (0, 1 or 2; an entry popped in the same cycle is not counted).
  - Both counters saturate at all-ones, clear only on reset (not on flush), and reset to 0.
- Undefined: ports and counters are absent; datapath behaviour is identical.

Test Plan:
1. Reset then stream: release reset; push instr 0x2002_0005/pc 0x0040_0000, then 0x2003_0007/0x0040_0004 back-to-back with out_ready=1 -> outputs appear 1 cycle later each; in_ready stays 1; out_valid 1 for 2 consecutive cycles.
2. Back-pressure to skid: out_ready=0, push A(pc 0x10) then B(pc 0x14) -> after A: FULL, in_ready=1. After B: SKID, in_ready=0. out_pc holds 0x10. Raise out_ready -> out_pc 0x10 then 0x14, then out_valid=0.
3. Push+pop in FULL: steady out_ready=1 with 8 pushes pc 0x0..0x1C -> 8 pops in order, no gaps, state never reaches SKID.
4. Flush priority: in SKID (A,B held), flush_i=1 with in_valid=1 carrying C -> next cycle out_valid=0, out_instr=NOP_INSTR, out_pc=0, in_ready=1. A, B and C are never output. With stats enabled, flush_drop_cnt=2.
5. Async reset mid-stream: assert reset low between edges while FULL -> out_valid=0, in_ready=0 immediately (no clock edge); outputs are NOP_INSTR/0.
6. Stats saturation (PIPE_STAGE_STATS_EN, CNT_W=4): hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15; flush does not clear it.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// Define PIPE_STAGE_STATS_EN to add stall_cnt / flush_drop_cnt statistics outputs.
module pipe_stage_reg #(
  parameter int unsigned           INSTR_W   = 32,
  parameter int unsigned           PC_W      = 32,
  parameter logic [INSTR_W-1:0]    NOP_INSTR = '0,
  parameter int unsigned           CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_drop_cnt
`endif
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]    main_pc_q, main_pc_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]    skid_pc_q, skid_pc_d;

  logic push;
  logic pop;

  // Handshake outputs decode only from state; reset gates in_ready immediately.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != SKID) & reset;
    out_instr = main_instr_q;
    out_pc    = main_pc_q;
  end

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= EMPTY;
      main_instr_q <= NOP_INSTR;
      main_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (flush_i) begin
      state_d      = EMPTY;
      main_instr_d = NOP_INSTR;
      main_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
      skid_pc_d    = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d      = FULL;
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end
        end
        FULL: begin
          if (push && pop) begin
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
          end else if (push) begin
            state_d      = SKID;
            skid_instr_d = in_instr;
            skid_pc_d    = in_pc;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        SKID: begin
          // Skid entry is always younger than main, so it only ever refills main.
          if (pop) begin
            state_d      = FULL;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]       drop_num;
  logic [CNT_W:0]   drop_sum;

  always_comb begin
    drop_num = 2'd0;
    if (flush_i) begin
      unique case (state_q)
        FULL:    drop_num = pop ? 2'd0 : 2'd1;
        SKID:    drop_num = pop ? 2'd1 : 2'd2;
        default: drop_num = 2'd0;
      endcase
    end
    drop_sum = {1'b0, drop_cnt_q} + {{(CNT_W-1){1'b0}}, drop_num};
    drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign stall_cnt      = stall_cnt_q;
  assign flush_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: inputs driven and outputs sampled on the falling edge.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef PIPE_STAGE_STATS_EN
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_drop_cnt;
`endif

  beat_t sb[$];
  beat_t exp_b;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .INSTR_W  (32),
    .PC_W     (32),
    .NOP_INSTR(NOP),
    .CNT_W    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush_i),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_instr (in_instr),
    .in_pc    (in_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc   (out_pc)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt     (stall_cnt),
    .flush_drop_cnt(flush_drop_cnt)
`endif
  );

  // Drives one cycle of stimulus; a beat accepted without flush enters the scoreboard.
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic r, input logic f);
    in_valid  = v;
    in_instr  = i;
    in_pc     = p;
    out_ready = r;
    flush_i   = f;
    if (v && in_ready && !f) sb.push_back('{instr: i, pc: p});
  endtask

  function automatic beat_t sb_pop();
    beat_t b;
    b = 'x;
    if (sb.size() != 0) b = sb.pop_front();
    return b;
  endfunction

  task automatic test_reset;
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, in_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_flags: got %b want 00", {out_valid, in_ready});
    end
    total++;
    if ({out_instr, out_pc} !== {NOP, 32'h0}) begin
      bad++; $display("FAIL reset_data: got %h/%h want %h/0", out_instr, out_pc, NOP);
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream;
    logic [31:0] ins[2] = '{32'h2002_0005, 32'h2003_0007};
    logic [31:0] pcs[2] = '{32'h0040_0000, 32'h0040_0004};
    logic        exp_ov[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int          vcnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      total++;
      if (out_valid !== exp_ov[c] || in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_flags c%0d: got v=%b r=%b want v=%b r=1", c, out_valid, in_ready, exp_ov[c]);
      end
      if (out_valid) vcnt++;
      if (c < 2) drive(1'b1, ins[c], pcs[c], 1'b1, 1'b0);
      else drive(1'b0, '0, '0, 1'b1, 1'b0);
      if (out_valid && out_ready) begin
        exp_b = sb_pop();
        total++;
        if ({out_instr, out_pc} !== exp_b) begin
          bad++; $display("FAIL stream_data c%0d: got %h/%h want %h/%h", c, out_instr, out_pc, exp_b.instr, exp_b.pc);
        end
      end
    end
    total++;
    if (vcnt != 2) begin
      bad++; $display("FAIL stream_valid_cycles: got %0d want 2", vcnt);
    end
  endtask

  task automatic test_skid;
    logic        v[7]   = '{1, 1, 0, 1, 0, 0, 0};
    logic [31:0] pc[7]  = '{32'h10, 32'h14, 0, 32'h18, 0, 0, 0};
    logic        r[7]   = '{0, 0, 0, 0, 1, 1, 1};
    logic        eov[7] = '{0, 1, 1, 1, 1, 1, 0};
    logic        eir[7] = '{1, 1, 0, 0, 0, 1, 1};
    logic [31:0] epc[7] = '{0, 32'h10, 32'h10, 32'h10, 32'h10, 32'h14, 0};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== eov[c] || in_ready !== eir[c] || (eov[c] && out_pc !== epc[c])) begin
        bad++;
        $display("FAIL skid_state c%0d: got v=%b r=%b pc=%h want v=%b r=%b pc=%h",
                 c, out_valid, in_ready, out_pc, eov[c], eir[c], epc[c]);
      end
      drive(v[c], 32'hA000_0000 | pc[c], pc[c], r[c], 1'b0);
      if (out_valid && out_ready) begin
        exp_b = sb_pop();
        total++;
        if ({out_instr, out_pc} !== exp_b) begin
          bad++; $display("FAIL skid_data c%0d: got %h/%h want %h/%h", c, out_instr, out_pc, exp_b.instr, exp_b.pc);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int pops = 0;
    int first = -1;
    int last = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL b2b_ready c%0d: got %b want 1", c, in_ready);
      end
      drive(c < 8, 32'h2400_0000 | 32'(c), 32'(c * 4), 1'b1, 1'b0);
      if (out_valid && out_ready) begin
        exp_b = sb_pop();
        pops++;
        if (first < 0) first = c;
        last = c;
        total++;
        if ({out_instr, out_pc} !== exp_b) begin
          bad++; $display("FAIL b2b_data c%0d: got %h/%h want %h/%h", c, out_instr, out_pc, exp_b.instr, exp_b.pc);
        end
      end
    end
    total++;
    if (pops != 8 || (last - first) != 7) begin
      bad++; $display("FAIL b2b_throughput: got pops=%0d span=%0d want 8/7", pops, last - first);
    end
  endtask

  task automatic test_flush;
    @(negedge clk); drive(1'b1, 32'hAAAA_0001, 32'h20, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 32'hBBBB_0002, 32'h24, 1'b0, 1'b0);
    @(negedge clk); drive(1'b1, 32'hCCCC_0003, 32'h28, 1'b0, 1'b1);
    sb.delete();
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, out_instr, out_pc} !== {1'b0, 1'b1, NOP, 32'h0}) begin
      bad++; $display("FAIL flush_skid: got v=%b r=%b %h/%h want v=0 r=1 %h/0", out_valid, in_ready, out_instr, out_pc, NOP);
    end
`ifdef PIPE_STAGE_STATS_EN
    total++;
    if (flush_drop_cnt !== 4'd2) begin
      bad++; $display("FAIL flush_drop_skid: got %0d want 2", flush_drop_cnt);
    end
`endif
    drive(1'b1, 32'hEEEE_0004, 32'h2C, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL flush_push_drop c%0d: got v=%b r=%b want v=0 r=1", c, out_valid, in_ready);
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
    end
`ifdef PIPE_STAGE_STATS_EN
    total++;
    if (flush_drop_cnt !== 4'd2) begin
      bad++; $display("FAIL flush_drop_empty: got %0d want 2", flush_drop_cnt);
    end
`endif
  endtask

  task automatic test_async_reset;
    @(negedge clk); drive(1'b1, 32'hF00D_0001, 32'h30, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, '0, '0, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h30) begin
      bad++; $display("FAIL async_pre: got v=%b pc=%h want v=1 pc=30", out_valid, out_pc);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, out_instr, out_pc} !== {1'b0, 1'b0, NOP, 32'h0}) begin
      bad++; $display("FAIL async_reset: got v=%b r=%b %h/%h want v=0 r=0 %h/0", out_valid, in_ready, out_instr, out_pc, NOP);
    end
`ifdef PIPE_STAGE_STATS_EN
    total++;
    if ({stall_cnt, flush_drop_cnt} !== 8'h00) begin
      bad++; $display("FAIL async_reset_stats: got %0d/%0d want 0/0", stall_cnt, flush_drop_cnt);
    end
`endif
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stats;
    @(negedge clk); drive(1'b1, 32'h5555_0001, 32'h40, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); drive(1'b0, '0, '0, 1'b0, 1'b0);
    end
    total++;
    if (stall_cnt !== 4'd15) begin
      bad++; $display("FAIL stall_sat: got %0d want 15", stall_cnt);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    @(negedge clk); drive(1'b0, '0, '0, 1'b0, 1'b0);
    sb.delete();
    total++;
    if (stall_cnt !== 4'd15 || flush_drop_cnt !== 4'd1) begin
      bad++; $display("FAIL stats_after_flush: got stall=%0d drop=%0d want 15/1", stall_cnt, flush_drop_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef PIPE_STAGE_STATS_EN
    test_stats();
`endif
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
